// File: rtl/pdm_rec_play_ctrl.sv
// pdm_rec_play_ctrl: records capture samples into the shared sample RAM and plays them back
// at a fixed pace to the PDM modulator, driving amp enable and a progress bar.
module pdm_rec_play_ctrl #(
    parameter int CLK_FREQ  = 100,
    parameter int SAMPLE_W  = 7,
    parameter int RAM_DEPTH = 131072,
    parameter int ADDR_W    = $clog2(RAM_DEPTH),
    parameter int PLAY_DIV  = 1280
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_record,
    input  logic                start_play,
    input  logic                stop,
    input  logic                cap_valid,
    input  logic [SAMPLE_W-1:0] cap_data,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [SAMPLE_W-1:0] mem_wdata,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic [SAMPLE_W-1:0] play_data,
    output logic                play_valid,
    output logic                aud_sd,
    output logic                recording,
    output logic                playing,
    output logic [15:0]         led,
    output logic [ADDR_W:0]     rec_len
);
    localparam logic [1:0] IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2, DRAIN = 2'd3;
    localparam int DIV_W = $clog2(PLAY_DIV);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PLAY_DIV - 1);
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(1 << (SAMPLE_W - 1));

    if (PLAY_DIV < 3 || CLK_FREQ < 1 || ADDR_W < 4) begin : g_bad_cfg
        $error("pdm_rec_play_ctrl: unsupported parameter set");
    end

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_addr, ptr;
    logic [DIV_W-1:0]  div;
    logic              rd_pend;
    logic [3:0]        n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_addr    <= '0;
            div        <= '0;
            rd_pend    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            play_data  <= MID;
            play_valid <= 1'b0;
            rec_len    <= '0;
        end else begin
            mem_we     <= 1'b0;
            play_valid <= 1'b0;
            rd_pend    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_record) begin
                        state  <= RECORD;
                        wr_ptr <= '0;
                    end else if (start_play && rec_len != '0) begin
                        state  <= PLAY;
                        rd_ptr <= '0;
                        div    <= '0;
                    end
                end
                RECORD: begin
                    if (cap_valid) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= cap_data;
                        wr_addr   <= wr_ptr;
                        if (wr_ptr != LAST) wr_ptr <= wr_ptr + 1'b1;
                    end
                    // a strobe coinciding with stop or filling the RAM is still stored and counted
                    if (stop || (cap_valid && wr_ptr == LAST)) begin
                        state   <= IDLE;
                        rec_len <= {1'b0, wr_ptr} + (ADDR_W+1)'(cap_valid);
                    end
                end
                default: begin
                    div <= (div == DIV_LAST) ? '0 : div + 1'b1;
                    if (state == PLAY && div == '0) begin
                        rd_pend <= 1'b1;
                        if ({1'b0, rd_ptr} == rec_len - 1'b1) state <= DRAIN;
                        else rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (rd_pend) begin
                        play_data  <= mem_rdata;
                        play_valid <= 1'b1;
                    end
                    if (stop || (state == DRAIN && div == DIV_LAST)) begin
                        state      <= IDLE;
                        play_data  <= MID;
                        play_valid <= 1'b0;
                        rd_pend    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // reads present rd_ptr continuously; only the divider-zero cycle is consumed
    assign mem_addr  = mem_we ? wr_addr : rd_ptr;
    assign recording = state == RECORD;
    assign playing   = state == PLAY || state == DRAIN;
    assign aud_sd    = playing;
    assign ptr       = recording ? wr_ptr : rd_ptr;
    assign n         = ptr[ADDR_W-1 -: 4];
    assign led       = (state == IDLE) ? '0 : 16'hFFFF >> (4'd15 - n);
endmodule

// File: tb/tb_pdm_rec_play_ctrl.sv
// tb_pdm_rec_play_ctrl: table vectors, directed corner sequences and randomized
// record/playback runs checked against a sample-timeline model.
module tb_pdm_rec_play_ctrl;
    localparam int DEPTH = 16;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic reset, start_record, start_play, stop, cap_valid;
    logic [6:0] cap_data, mem_wdata, mem_rdata, play_data;
    logic [3:0] mem_addr;
    logic mem_we, play_valid, aud_sd, recording, playing;
    logic [15:0] led;
    logic [4:0] rec_len;
    logic [6:0] ram [DEPTH];
    int checks = 0, errors = 0, we_cnt = 0;
    logic [10:0] wlog [$];

    typedef struct {
        logic rec, ply, stp, cv;
        logic [6:0] d;
        logic ex_rec, ex_ply, ex_we;
        logic [3:0] ex_addr;
        logic [6:0] ex_wd;
        logic [15:0] ex_led;
        logic [4:0] ex_len;
    } vec_t;
    vec_t tv [12];

    always #5 clk = ~clk;

    pdm_rec_play_ctrl #(.RAM_DEPTH(DEPTH), .PLAY_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start_record(start_record), .start_play(start_play),
        .stop(stop), .cap_valid(cap_valid), .cap_data(cap_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .play_data(play_data),
        .play_valid(play_valid), .aud_sd(aud_sd), .recording(recording), .playing(playing),
        .led(led), .rec_len(rec_len)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            wlog.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic record(input logic [6:0] d[$], input int gmax, input int smode);
        we_cnt = 0;
        wlog.delete();
        start_record = 1'b1;
        tick;
        start_record = 1'b0;
        foreach (d[i]) begin
            cap_valid = 1'b1;
            cap_data = d[i];
            stop = (smode == 1 && i == d.size() - 1);
            if (i == DEPTH - 1) chk("led full", led, 16'hFFFF);
            tick;
            cap_valid = 1'b0;
            stop = 1'b0;
            repeat ($urandom_range(gmax, 0)) tick;
        end
        if (smode == 2) begin
            stop = 1'b1;
            tick;
            stop = 1'b0;
        end
        tick;
    endtask

    task automatic rec_verify(input logic [6:0] d[$], input string tag);
        int n;
        n = (d.size() > DEPTH) ? DEPTH : d.size();
        chk({tag, " rec_len"}, rec_len, n);
        chk({tag, " recording"}, recording, 0);
        chk({tag, " writes"}, we_cnt, n);
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk({tag, " write"}, wlog[i], {i[3:0], d[i]});
            chk({tag, " ram"}, ram[i], d[i]);
        end
    endtask

    // sample j of L is expected 3+DIV*j cycles after the start_play cycle; silence after the last period
    task automatic play_check(input logic [6:0] d[$], input string tag);
        int L;
        logic [6:0] last;
        L = (d.size() > DEPTH) ? DEPTH : d.size();
        last = 7'd64;
        start_play = 1'b1;
        tick;
        start_play = 1'b0;
        for (int k = 1; k <= DIV * L + 2; k++) begin
            bit v;
            v = (k >= 3) && ((k - 3) % DIV == 0) && ((k - 3) / DIV < L);
            if (v) last = d[(k - 3) / DIV];
            if (k == DIV * L + 1) last = 7'd64;
            chk({tag, " aud_sd"}, aud_sd, k <= DIV * L);
            chk({tag, " play_valid"}, play_valid, v);
            chk({tag, " play_data"}, play_data, last);
            tick;
        end
    endtask

    initial begin
        logic [6:0] d [$];
        int m, sm, nv;
        tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 4'd0, 7'd0,  16'h0000, 5'd0};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0, 4'd0, 7'd0,  16'h0001, 5'd0};
        tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd10, 1'b1, 1'b0, 1'b1, 4'd0, 7'd10, 16'h0003, 5'd0};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0, 4'd0, 7'd0,  16'h0003, 5'd0};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd20, 1'b1, 1'b0, 1'b1, 4'd1, 7'd20, 16'h0007, 5'd0};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd30, 1'b1, 1'b0, 1'b1, 4'd2, 7'd30, 16'h000F, 5'd0};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0, 4'd0, 7'd0,  16'h000F, 5'd0};
        tv[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0, 4'd0, 7'd0,  16'h000F, 5'd0};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd40, 1'b1, 1'b0, 1'b1, 4'd3, 7'd40, 16'h001F, 5'd0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 7'd50, 1'b0, 1'b0, 1'b1, 4'd4, 7'd50, 16'h0000, 5'd5};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0, 1'b0, 4'd0, 7'd0,  16'h0000, 5'd5};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'd99, 1'b0, 1'b0, 1'b0, 4'd0, 7'd0,  16'h0000, 5'd5};

        reset = 1'b1;
        start_record = 1'b0;
        start_play = 1'b0;
        stop = 1'b0;
        cap_valid = 1'b0;
        cap_data = '0;
        repeat (3) tick;
        reset = 1'b0;
        chk("reset play_data", play_data, 64);
        chk("reset mem_we", mem_we, 0);
        chk("reset rec_len", rec_len, 0);
        chk("reset led", led, 0);

        we_cnt = 0;
        wlog.delete();
        foreach (tv[i]) begin
            start_record = tv[i].rec;
            start_play = tv[i].ply;
            stop = tv[i].stp;
            cap_valid = tv[i].cv;
            cap_data = tv[i].d;
            tick;
            chk($sformatf("vec%0d recording", i), recording, tv[i].ex_rec);
            chk($sformatf("vec%0d playing", i), playing, tv[i].ex_ply);
            chk($sformatf("vec%0d mem_we", i), mem_we, tv[i].ex_we);
            chk($sformatf("vec%0d led", i), led, tv[i].ex_led);
            chk($sformatf("vec%0d rec_len", i), rec_len, tv[i].ex_len);
            if (tv[i].ex_we) begin
                chk($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].ex_addr);
                chk($sformatf("vec%0d mem_wdata", i), mem_wdata, tv[i].ex_wd);
            end
        end
        start_record = 1'b0;
        start_play = 1'b0;
        stop = 1'b0;
        cap_valid = 1'b0;
        tick;
        d = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50};
        rec_verify(d, "rec5");
        play_check(d, "play5");

        start_play = 1'b1;
        tick;
        start_play = 1'b0;
        nv = 0;
        for (int k = 1; k <= 13; k++) begin
            if (play_valid) nv++;
            if (k == 6) chk("rec during play", {recording, playing}, 2'b01);
            start_record = (k == 5);
            stop = (k == 13);
            tick;
        end
        start_record = 1'b0;
        stop = 1'b0;
        chk("abort valids before stop", nv, 3);
        chk("abort play_data", play_data, 64);
        chk("abort aud_sd", aud_sd, 0);
        chk("abort rec_len kept", rec_len, 5);
        nv = 0;
        repeat (8) begin
            if (play_valid) nv++;
            tick;
        end
        chk("abort no more valids", nv, 0);

        d.delete();
        for (int i = 0; i < 20; i++) d.push_back(7'(i));
        record(d, 0, 0);
        rec_verify(d, "full rec");
        play_check(d, "full play");

        for (int it = 0; it < 8; it++) begin
            d.delete();
            m = $urandom_range(20, 1);
            for (int i = 0; i < m; i++) d.push_back(7'($urandom));
            sm = (m >= DEPTH) ? $urandom_range(2, 0) : $urandom_range(2, 1);
            record(d, 2, sm);
            rec_verify(d, $sformatf("rand%0d rec", it));
            play_check(d, $sformatf("rand%0d play", it));
        end

        start_play = 1'b1;
        tick;
        start_play = 1'b0;
        repeat (6) tick;
        reset = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        chk("midplay reset mem_addr", mem_addr, 0);
        chk("midplay reset mem_we", mem_we, 0);
        chk("midplay reset mem_wdata", mem_wdata, 0);
        chk("midplay reset play_data", play_data, 64);
        chk("midplay reset play_valid", play_valid, 0);
        chk("midplay reset aud_sd", aud_sd, 0);
        chk("midplay reset recording", recording, 0);
        chk("midplay reset playing", playing, 0);
        chk("midplay reset led", led, 0);
        chk("midplay reset rec_len", rec_len, 0);
        start_play = 1'b1;
        tick;
        start_play = 1'b0;
        chk("empty play ignored", playing, 0);
        repeat (3) tick;
        chk("empty play no valid", play_valid, 0);
        chk("empty play aud_sd", aud_sd, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
